// File: rtl/systolic_pkg.sv
// Shared definitions for the 4x4 output-stationary systolic array slice:
// per-PE control codes, the sequencer state encoding and the default
// input-register latency of the array.
package systolic_pkg;

    localparam int ALIGN_DEFAULT = 1;

    localparam logic [1:0] CTL_HOLD    = 2'b00;
    localparam logic [1:0] CTL_COMPUTE = 2'b01;
    localparam logic [1:0] CTL_SHIFT   = 2'b10;
    localparam logic [1:0] CTL_CLEAR   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/skew_line.sv
// Fixed-depth delay line for one operand lane.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   din        lane value entering the line
//   dout       din delayed by `depth` cycles (depth 0 is a plain wire)
module skew_line #(
    parameter int width = 8,
    parameter int depth = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    // At least one stage is declared so depth 0 stays legal; that stage is
    // simply never observed and optimises away.
    localparam int STAGES = (depth > 0) ? depth : 1;

    logic [width-1:0] stage [STAGES];

    // NOTE: the stage array is reset element by element; the array reads
    // these lines right after reset, so they must hold zeros, not X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = (depth == 0) ? din : stage[STAGES-1];

endmodule

// File: rtl/array_sequencer.sv
// Transmit-side driver for the output-stationary systolic array.
// Accepts operand beats, skews them into the diagonal wavefront, generates
// the per-PE control words and drains the result rows as a stream.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, k_len      tile request and beat count (sampled in IDLE only)
//   busy, done        not-IDLE flag, one-cycle completion pulse
//   s_valid/s_ready   operand beat handshake; s_w weights, s_in inputs
//   ws, ins, ctls     skewed operands and column-major 2-bit PE controls
//   outs              top-row result register of the array
//   r_valid/r_ready   result row handshake; r_data = outs, r_last final row
module array_sequencer
    import systolic_pkg::*;
#(
    parameter int width   = 8,
    parameter int decimal = 4,
    parameter int rows    = 4,
    parameter int cols    = 4,
    parameter int kmax    = 16,
    parameter int ALIGN   = ALIGN_DEFAULT,
    localparam int KW     = $clog2(kmax + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [KW-1:0]            k_len,
    output logic                     busy,
    output logic                     done,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [rows*width-1:0]    s_w,
    input  logic [cols*width-1:0]    s_in,
    output logic [rows*width-1:0]    ws,
    output logic [cols*width-1:0]    ins,
    output logic [rows*cols*2-1:0]   ctls,
    input  logic [cols*width-1:0]    outs,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [cols*width-1:0]    r_data,
    output logic                     r_last
);

    // The fixed-point position only matters to the array; reject nonsense.
    if (decimal >= width || kmax < 1) begin : g_bad_params
        $error("array_sequencer: decimal must be below width and kmax >= 1");
    end

    // Last PE computes DEPTH cycles after its beat was accepted.
    localparam int DEPTH = ALIGN + rows + cols - 1;
    localparam int RW    = $clog2(rows + 1);
    localparam int CW    = (KW > RW) ? KW : RW;

    state_t            state, state_nxt;
    logic [KW-1:0]     k_q;
    logic [CW-1:0]     cnt;          // beats in FEED, handshakes in DRAIN
    logic [DEPTH-1:0]  act_pipe;     // bit i = FEED activity i+1 cycles ago
    logic [rows*width-1:0] w_reg;
    logic [cols*width-1:0] in_reg;
    logic              done_q;
    logic              accept;
    logic              handshake;

    assign busy      = (state != ST_IDLE);
    assign done      = done_q;
    assign s_ready   = (state == ST_FEED);
    assign accept    = s_ready && s_valid;
    assign r_valid   = (state == ST_DRAIN) && (cnt < CW'(rows));
    assign r_last    = (state == ST_DRAIN) && (cnt == CW'(rows - 1));
    assign handshake = r_valid && r_ready;
    assign r_data    = outs;

    // NOTE: combinational blocks assign every output a default first, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start && k_len != '0) state_nxt = ST_FEED;
            ST_FEED:  if (accept && cnt == CW'(k_q) - CW'(1)) state_nxt = ST_FLUSH;
            // Nothing enters the pipe now, so once only the top bit is left
            // the last PE is computing this cycle.
            ST_FLUSH: if (act_pipe[DEPTH-2:0] == '0) state_nxt = ST_DRAIN;
            ST_DRAIN: if (handshake && cnt == CW'(rows - 1)) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // PE(r,c) computes when its operands arrive: 1+ALIGN+r+c after the beat.
    always_comb begin
        ctls = '0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                ctls[2*(c*rows+r) +: 2] = act_pipe[ALIGN+r+c] ? CTL_COMPUTE : CTL_HOLD;
            end
        end
        if (state == ST_CLEAR) begin
            ctls = {rows*cols{CTL_CLEAR}};
        end else if (handshake) begin
            ctls = {rows*cols{CTL_SHIFT}};
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            k_q      <= '0;
            cnt      <= '0;
            act_pipe <= '0;
            w_reg    <= '0;
            in_reg   <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            done_q   <= (state == ST_CLEAR) ||
                        (state == ST_IDLE && start && k_len == '0);
            act_pipe <= {act_pipe[DEPTH-2:0], state == ST_FEED};
            // Idle FEED cycles and all other states push zero bubbles.
            w_reg    <= accept ? s_w  : '0;
            in_reg   <= accept ? s_in : '0;
            case (state)
                ST_IDLE: if (start) begin
                    k_q <= k_len;
                    cnt <= '0;
                end
                ST_FEED:  if (accept)    cnt <= (state_nxt == ST_FLUSH) ? '0 : cnt + CW'(1);
                ST_DRAIN: if (handshake) cnt <= (state_nxt == ST_CLEAR) ? '0 : cnt + CW'(1);
                default: ;
            endcase
        end
    end

    for (genvar r = 0; r < rows; r++) begin : g_w_skew
        skew_line #(.width(width), .depth(r)) u_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (w_reg[r*width +: width]),
            .dout (ws[r*width +: width])
        );
    end

    for (genvar c = 0; c < cols; c++) begin : g_in_skew
        skew_line #(.width(width), .depth(c)) u_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (in_reg[c*width +: width]),
            .dout (ins[c*width +: width])
        );
    end

endmodule

// File: tb/tb_array_sequencer.sv
// Directed testbench for array_sequencer with a behavioural 4x4
// output-stationary array attached to ws/ins/ctls/outs.
module tb_array_sequencer;

    localparam logic [31:0] ALL_SHIFT = 32'hAAAA_AAAA;
    localparam logic [31:0] ALL_CLEAR = 32'hFFFF_FFFF;
    localparam int          FLUSH_GAP = 9;  // accept -> first DRAIN cycle

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  k_len = '0;
    logic        busy, done;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_w = '0, s_in = '0;
    logic [31:0] ws, ins, ctls, outs, r_data;
    logic        r_valid, r_last;
    logic        r_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] bw [16];
    logic [31:0] bi [16];
    logic [31:0] exp_rows [4];

    // Behavioural array: weights hop right, inputs hop down, one register
    // per PE (the first register being the ALIGN stage).
    logic [7:0] wp  [4][4];
    logic [7:0] ip  [4][4];
    logic [7:0] acc [4][4];
    logic       arr_clr = 1'b0;

    array_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy), .done(done),
        .s_valid(s_valid), .s_ready(s_ready), .s_w(s_w), .s_in(s_in),
        .ws(ws), .ins(ins), .ctls(ctls), .outs(outs),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (arr_clr) begin
                    wp[r][c]  <= '0;
                    ip[r][c]  <= '0;
                    acc[r][c] <= '0;
                end else begin
                    if (c == 0) wp[r][c] <= ws[r*8 +: 8];
                    else        wp[r][c] <= wp[r][c-1];
                    if (r == 0) ip[r][c] <= ins[c*8 +: 8];
                    else        ip[r][c] <= ip[r-1][c];
                    case (ctls[2*(c*4+r) +: 2])
                        2'b01: acc[r][c] <= acc[r][c] + 8'((16'(wp[r][c]) * 16'(ip[r][c])) >> 4);
                        2'b10: begin
                            if (r == 3) acc[r][c] <= '0;
                            else        acc[r][c] <= acc[r+1][c];
                        end
                        2'b11: acc[r][c] <= '0;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign outs = {acc[0][3], acc[0][2], acc[0][1], acc[0][0]};

    task automatic clear_array();
        @(negedge clk); arr_clr = 1'b1;
        @(negedge clk); arr_clr = 1'b0;
    endtask

    task automatic load_identity();
        for (int k = 0; k < 4; k++) begin
            bw[k] = 32'h10 << (8 * k);
            for (int c = 0; c < 4; c++) bi[k][c*8 +: 8] = 8'(k * 4 + c + 1);
        end
        exp_rows[0] = 32'h0403_0201;
        exp_rows[1] = 32'h0807_0605;
        exp_rows[2] = 32'h0C0B_0A09;
        exp_rows[3] = 32'h100F_0E0D;
    endtask

    // Feeds k beats, holding s_valid low for gap_len cycles before beat
    // gap_at. Returns at the first cycle after the last accept.
    task automatic run_feed(input int k, input int gap_at, input int gap_len,
                            output int last_acc);
        int b = 0;
        int gap = 0;
        int guard = 0;
        last_acc = 0;
        @(negedge clk); start = 1'b1; k_len = 5'(k);
        @(negedge clk); start = 1'b0;
        while (b < k && guard < 64) begin
            if (b == gap_at && gap < gap_len) begin
                s_valid = 1'b0; s_w = '0; s_in = '0; gap++;
            end else begin
                s_valid = 1'b1; s_w = bw[b]; s_in = bi[b];
            end
            #1;
            checks++;
            if (s_ready !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL feed_ready: s_ready=%b busy=%b expected 1 1 (beat %0d)", s_ready, busy, b);
            end
            if (s_valid && s_ready) begin
                last_acc = cyc;
                b++;
            end
            @(negedge clk);
            guard++;
        end
        s_valid = 1'b0; s_w = '0; s_in = '0;
        #1;
        checks++;
        if (s_ready !== 1'b0 || busy !== 1'b1 || b != k) begin
            errors++;
            $display("FAIL feed_end: s_ready=%b busy=%b beats=%0d expected 0 1 %0d", s_ready, busy, b, k);
        end
    endtask

    // Waits for DRAIN, drains with a repeating r_ready pattern (bit 0 first),
    // then checks the CLEAR cycle and the done pulse.
    task automatic run_drain(input logic [3:0] pat, input bit pulse_start, input int last_acc);
        int guard = 0;
        int row = 0;
        int i = 0;
        int shifts = 0;
        while (!r_valid && guard < 40) begin
            checks++;
            if (done !== 1'b0 || ctls === ALL_SHIFT || ctls === ALL_CLEAR) begin
                errors++;
                $display("FAIL flush_ctl: done=%b ctls=%h expected done=0 and no shift/clear", done, ctls);
            end
            @(negedge clk); #1;
            guard++;
        end
        checks++;
        if (r_valid !== 1'b1 || cyc - last_acc != FLUSH_GAP) begin
            errors++;
            $display("FAIL flush_len: r_valid=%b gap=%0d expected 1 %0d", r_valid, cyc - last_acc, FLUSH_GAP);
        end
        while (row < 4 && i < 40) begin
            r_ready = pat[i % 4];
            if (pulse_start && i == 1) begin
                start = 1'b1; k_len = 5'd4;
            end else begin
                start = 1'b0;
            end
            #1;
            checks++;
            if (r_valid !== 1'b1 || r_data !== exp_rows[row] || r_last !== (row == 3) || done !== 1'b0) begin
                errors++;
                $display("FAIL drain_row%0d: valid=%b data=%h last=%b done=%b expected 1 %h %b 0",
                         row, r_valid, r_data, r_last, done, exp_rows[row], row == 3);
            end
            checks++;
            if (ctls !== (r_ready ? ALL_SHIFT : 32'h0)) begin
                errors++;
                $display("FAIL drain_ctl: ctls=%h expected %h", ctls, r_ready ? ALL_SHIFT : 32'h0);
            end
            if (ctls === ALL_SHIFT) shifts++;
            if (r_ready) row++;
            i++;
            @(negedge clk);
        end
        r_ready = 1'b0; start = 1'b0;
        #1;
        checks++;
        if (ctls !== ALL_CLEAR || r_valid !== 1'b0 || done !== 1'b0 || shifts != 4) begin
            errors++;
            $display("FAIL clear_cycle: ctls=%h r_valid=%b done=%b shifts=%0d expected %h 0 0 4",
                     ctls, r_valid, done, shifts, ALL_CLEAR);
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ctls !== 32'h0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b ctls=%h expected 1 0 0", done, busy, ctls);
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL after_done: done=%b busy=%b s_ready=%b expected 0 0 0", done, busy, s_ready);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({busy, done, s_ready, r_valid, r_last} !== 5'b0 || ws !== '0 || ins !== '0 || ctls !== '0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b s_ready=%b r_valid=%b r_last=%b ws=%h ins=%h ctls=%h expected all 0",
                     name, busy, done, s_ready, r_valid, r_last, ws, ins, ctls);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk); #1;
        check_reset_values("reset_values");
        rst = 1'b1;
        clear_array();
    endtask

    task automatic test_identity();
        int la;
        load_identity();
        run_feed(4, -1, 0, la);
        run_drain(4'b1111, 1'b0, la);
    endtask

    task automatic test_gap();
        int la;
        load_identity();
        run_feed(4, 2, 3, la);
        run_drain(4'b1111, 1'b0, la);
    endtask

    task automatic test_stall();
        int la;
        load_identity();
        run_feed(4, -1, 0, la);
        run_drain(4'b1001, 1'b0, la);
    endtask

    task automatic test_zero_len();
        @(negedge clk); start = 1'b1; k_len = 5'd0;
        @(negedge clk); start = 1'b0; #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: done=%b busy=%b expected 1 0", done, busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (done !== 1'b0 || s_ready !== 1'b0 || r_valid !== 1'b0 || ctls !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_len_idle: done=%b s_ready=%b r_valid=%b ctls=%h busy=%b expected 0 0 0 0 0",
                         done, s_ready, r_valid, ctls, busy);
            end
        end
    endtask

    task automatic test_mid_reset();
        int la;
        load_identity();
        @(negedge clk); start = 1'b1; k_len = 5'd4;
        @(negedge clk); start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            s_valid = 1'b1; s_w = bw[b]; s_in = bi[b];
            if (b < 2) @(negedge clk);
        end
        #1; rst = 1'b0; #1;
        check_reset_values("mid_reset_async");
        @(negedge clk); #1;
        check_reset_values("mid_reset_next");
        s_valid = 1'b0; s_w = '0; s_in = '0;
        rst = 1'b1;
        clear_array();
        bw[0] = 32'h3040_2010;
        bi[0] = 32'h0403_0201;
        exp_rows[0] = 32'h0403_0201;
        exp_rows[1] = 32'h0806_0402;
        exp_rows[2] = 32'h100C_0804;
        exp_rows[3] = 32'h0C09_0603;
        run_feed(1, -1, 0, la);
        run_drain(4'b1111, 1'b0, la);
    endtask

    task automatic test_start_in_drain();
        int la;
        load_identity();
        run_feed(4, -1, 0, la);
        run_drain(4'b1111, 1'b1, la);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_gap();
        test_stall();
        test_zero_len();
        test_mid_reset();
        test_start_in_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
